// File: rtl/bsg_pll_scan_master.sv
// Serial scan master for a PLL configuration port: loads a parallel word MSB-first
// over chip-select/scan-clock/sdi, optionally pulsing the PLL reset first, and returns the word read from sdo.
module bsg_pll_scan_master #(
  parameter int cfg_width_p  = 32,
  parameter int clk_div_p    = 4,
  parameter int reset_hold_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [cfg_width_p-1:0] data_i,
  input  logic                   pll_reset_i,
  output logic                   ready_o,
  output logic                   chip_select_o,
  output logic                   scn_clk_o,
  output logic                   sdi_o,
  output logic                   rstb_o,
  input  logic                   sdo_i,
  output logic                   v_o,
  output logic [cfg_width_p-1:0] data_o
);

  localparam int phase_w = $clog2(clk_div_p + 1);
  localparam int bit_w   = $clog2(cfg_width_p + 1);
  localparam int hold_w  = $clog2(reset_hold_p + 1);

  localparam logic [phase_w-1:0] phase_last = phase_w'(clk_div_p - 1);
  localparam logic [bit_w-1:0]   bit_last   = bit_w'(cfg_width_p - 1);
  localparam logic [hold_w-1:0]  hold_last  = hold_w'(reset_hold_p - 1);

  typedef enum logic [2:0] {IDLE, PRST, LOAD, HOLD, DONE} state_e;

  state_e                 state_r, state_n;
  logic [phase_w-1:0]     phase_r, phase_n;
  logic                   high_r, high_n;
  logic [bit_w-1:0]       bit_r, bit_n;
  logic [hold_w-1:0]      hold_r, hold_n;
  logic [cfg_width_p-1:0] cfg_r, cfg_n;
  logic [cfg_width_p-1:0] cap_r, cap_n;
  logic                   ready_r, ready_n;
  logic                   cs_r, cs_n;
  logic                   scn_r, scn_n;
  logic                   sdi_r, sdi_n;
  logic                   rstb_r, rstb_n;
  logic                   v_r, v_n;
  logic [cfg_width_p-1:0] data_r, data_n;
  logic                   start_load;
  logic [cfg_width_p-1:0] load_word;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      phase_r <= '0;
      high_r  <= 1'b0;
      bit_r   <= '0;
      hold_r  <= '0;
      cfg_r   <= '0;
      cap_r   <= '0;
      ready_r <= 1'b1;
      cs_r    <= 1'b0;
      scn_r   <= 1'b0;
      sdi_r   <= 1'b0;
      rstb_r  <= 1'b0;
      v_r     <= 1'b0;
      data_r  <= '0;
    end else begin
      state_r <= state_n;
      phase_r <= phase_n;
      high_r  <= high_n;
      bit_r   <= bit_n;
      hold_r  <= hold_n;
      cfg_r   <= cfg_n;
      cap_r   <= cap_n;
      ready_r <= ready_n;
      cs_r    <= cs_n;
      scn_r   <= scn_n;
      sdi_r   <= sdi_n;
      rstb_r  <= rstb_n;
      v_r     <= v_n;
      data_r  <= data_n;
    end
  end

  // Outputs are computed from the next state so every pin comes straight off a flop.
  always_comb begin
    state_n    = state_r;
    phase_n    = phase_r;
    high_n     = high_r;
    bit_n      = bit_r;
    hold_n     = hold_r;
    cfg_n      = cfg_r;
    cap_n      = cap_r;
    sdi_n      = sdi_r;
    rstb_n     = rstb_r;
    v_n        = 1'b0;
    data_n     = data_r;
    start_load = 1'b0;
    load_word  = cfg_r;

    unique case (state_r)
      IDLE, DONE: begin
        if (v_i) begin
          if (pll_reset_i) begin
            state_n = PRST;
            hold_n  = '0;
            cfg_n   = data_i;
          end else begin
            start_load = 1'b1;
            load_word  = data_i;
          end
        end else begin
          state_n = IDLE;
        end
      end
      PRST: begin
        if (hold_r == hold_last) start_load = 1'b1;
        else                     hold_n = hold_r + hold_w'(1);
      end
      LOAD: begin
        if (phase_r == phase_last) begin
          phase_n = '0;
          if (!high_r) begin
            // last low-phase cycle: sample sdo just before the rising edge
            high_n   = 1'b1;
            cap_n    = cap_r << 1;
            cap_n[0] = sdo_i;
          end else if (bit_r == bit_last) begin
            high_n  = 1'b0;
            state_n = HOLD;
          end else begin
            high_n = 1'b0;
            bit_n  = bit_r + bit_w'(1);
            sdi_n  = cfg_r[cfg_width_p-1];
            cfg_n  = cfg_r << 1;
          end
        end else begin
          phase_n = phase_r + phase_w'(1);
        end
      end
      HOLD: begin
        if (phase_r == phase_last) begin
          state_n = DONE;
          v_n     = 1'b1;
          data_n  = cap_r;
        end else begin
          phase_n = phase_r + phase_w'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (start_load) begin
      state_n = LOAD;
      phase_n = '0;
      high_n  = 1'b0;
      bit_n   = '0;
      sdi_n   = load_word[cfg_width_p-1];
      cfg_n   = load_word << 1;
      rstb_n  = 1'b1;
    end
    if (state_n == PRST) rstb_n = 1'b0;

    ready_n = (state_n == IDLE) || (state_n == DONE);
    cs_n    = (state_n == LOAD) || (state_n == HOLD);
    scn_n   = (state_n == LOAD) && high_n;
  end

  assign ready_o       = ready_r;
  assign chip_select_o = cs_r;
  assign scn_clk_o     = scn_r;
  assign sdi_o         = sdi_r;
  assign rstb_o        = rstb_r;
  assign v_o           = v_r;
  assign data_o        = data_r;

endmodule

// File: doc/bsg_pll_scan_master.md
# bsg_pll_scan_master

Serial configuration master for the chip's PLL scan port. Accepts a parallel configuration word through a valid/ready handshake. Drives the PLL serial pins (chip select, scan clock, serial data in, active-low reset) to load the word MSB-first. Captures the word shifted out on the PLL's serial data out and returns it as readback. One instance sits directly upstream of each PLL macro, either the core-clock PLL or the io-master-clock PLL, and drives its `in_chip_select`, `in_scn_clk`, `in_sdi` and `in_rstb` pins and consumes its `out_sdo`.

## Interface
Parameters:
- `cfg_width_p`, 32, configuration/readback word width (≥1).
- `clk_div_p`, 4, `clk_i` cycles per scan-clock half period (≥1).
- `reset_hold_p`, 16, `clk_i` cycles `rstb_o` is held low on a PLL-reset request (≥1).

Ports:
- `clk_i`, in, 1, sole clock.
- `reset_i`, in, 1, synchronous, active-high.
- `v_i`, in, 1, request valid.
- `data_i`, in, `cfg_width_p`, configuration word.
- `pll_reset_i`, in, 1, qualifies `v_i`: pulse PLL reset before shifting.
- `ready_o`, out, 1, idle; request accepted when `v_i & ready_o`.
- `chip_select_o`, out, 1, PLL scan chip select, active-high.
- `scn_clk_o`, out, 1, PLL scan clock.
- `sdi_o`, out, 1, PLL serial data in.
- `rstb_o`, out, 1, PLL reset, active-low.
- `sdo_i`, in, 1, PLL serial data out.
- `v_o`, out, 1, one-cycle readback-valid pulse.
- `data_o`, out, `cfg_width_p`, readback word; held until the next `v_o`.

## Operation
- States:
  - IDLE: `ready_o`=1. On accept, go to PRST if `pll_reset_i`, else LOAD.
  - PRST: `rstb_o`=0 for `reset_hold_p` cycles, then go to LOAD with `rstb_o`=1.
  - LOAD: `chip_select_o`=1. Shifts `cfg_width_p` bits. Each bit is a low phase of `clk_div_p` cycles then a high phase of `clk_div_p` cycles.
  - HOLD: `chip_select_o`=1, `scn_clk_o`=0, lasts `clk_div_p` cycles.
  - DONE: one cycle. `chip_select_o`=0, `v_o`=1, `ready_o`=1. Behaves as IDLE, so it may accept a new request.
- Bit order: `data_i` is latched on accept. Bit i, counted from 0, drives `data_i[cfg_width_p-1-i]`.
- `sdi_o` changes only in the first cycle of a low phase. It is stable through the following rising edge, on which the PLL samples it.
- `sdo_i` is registered in the last cycle of each low phase, before each rising edge. The first sample goes to `data_o[cfg_width_p-1]` and the last to `data_o[0]`.
- Bit and phase counters are sized `$clog2` of their maximum count plus one. No wrap within an operation.
- `rstb_o` after reset is 0. It stays 0 until the first accepted request:
  - with `pll_reset_i`=0, it goes to 1 in the cycle after accept;
  - with `pll_reset_i`=1, it goes to 1 after PRST.
  - Once 1, it stays 1 except during PRST.
- `v_i` while `ready_o`=0 is ignored; there is no queuing.
- Back-to-back requests: a request accepted in the DONE cycle starts the next cycle. `chip_select_o` is therefore low for exactly one cycle between loads.
- `reset_i` at any time:
  - all state is aborted;
  - outputs take their reset values in the next cycle;
  - no `v_o` is produced for the aborted load;
  - `data_o` is cleared.

## Timing
- Reset values: `ready_o`=1, `chip_select_o`=0, `scn_clk_o`=0, `sdi_o`=0, `rstb_o`=0, `v_o`=0, `data_o`=0.
- All outputs are registered. Let T be the accept cycle, d = `clk_div_p`, W = `cfg_width_p`, R = (`pll_reset_i` ? `reset_hold_p` : 0).
- PRST: `rstb_o`=0 during T+1 … T+R.
- Bit i low phase: T+R+1+2di … T+R+d+2di. Bit i high phase: T+R+1+d+2di … T+R+2d+2di.
- `chip_select_o` rises at T+R+1. `scn_clk_o`=0 outside high phases.
- HOLD: T+R+2dW+1 … T+R+2dW+d.
- `v_o` is asserted, `chip_select_o` is 0 and `ready_o` is 1 at T+R+2dW+d+1.
- `ready_o` is 0 during T+1 … T+R+2dW+d.

## Test plan
- Reset: assert `reset_i` 3 cycles → `ready_o`=1, `rstb_o`=0, `chip_select_o`=`scn_clk_o`=`v_o`=0, `data_o`=0.
- Load (d=2, W=8, `data_i`=0xA5, `pll_reset_i`=0; PLL model preloaded 0x3C) → `sdi_o` sequence 1,0,1,0,0,1,0,1 on 8 rising edges; `rstb_o`=1 at T+1; `v_o` at T+35 with `data_o`=0x3C; model chain contents = 0xA5.
- PLL reset (d=2, W=8, `reset_hold_p`=4, `pll_reset_i`=1) → `rstb_o`=0 at T+1…T+4 and 1 at T+5; `chip_select_o` rises at T+5; `v_o` at T+39.
- Busy/back-to-back: pulse `v_i` mid-load → ignored, exactly one `v_o`; hold `v_i` high → second accept in the DONE cycle, `chip_select_o` low for exactly 1 cycle.
- Mid-shift reset: assert `reset_i` during bit 3 → next cycle `chip_select_o`=0, `scn_clk_o`=0, `rstb_o`=0, `ready_o`=1, `data_o`=0; no `v_o` ever for that load.
- Boundary (d=1, W=1, `data_i`=1, `sdo_i`=1) → `scn_clk_o` high only at T+2, `v_o` at T+4 with `data_o`=1.
